mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single instruction-memory/backing-memory line port between the instruction-cache refill path and the data-cache refill/writeback path. It arbitrates between the two requesters, issues one line transaction at a time to memory, buffers the 512-bit response and routes it back to its owner. It sits between the fetch-stage icache, the dcache, and the memory wrapper.

## Interface
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits
- LINE_W, 512, line width in bits
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- i_req_valid_i / i_req_ready_o  in/out  1  icache request handshake
- i_req_addr_i  in  32  icache line address
- i_flush_i  in  1  drop any in-flight instruction response (taken branch)
- i_rsp_valid_o / i_rsp_ready_i  out/in  1  icache response handshake
- i_rsp_addr_o  out  32  address of returned line
- i_rsp_line_o  out  LINE_W  returned line
- d_req_valid_i / d_req_ready_o  in/out  1  dcache request handshake
- d_req_addr_i  in  32  dcache line address
- d_req_we_i  in  1  1 = writeback, 0 = refill
- d_req_wdata_i  in  LINE_W  writeback data
- d_rsp_valid_o / d_rsp_ready_i  out/in  1  dcache response handshake
- d_rsp_addr_o  out  32; d_rsp_line_o  out  LINE_W
- m_req_valid_o / m_req_ready_i  out/in  1  memory request handshake
- m_req_addr_o  out  32; m_req_we_o  out  1; m_req_wdata_o  out  LINE_W
- m_rsp_valid_i / m_rsp_ready_o  in/out  1  memory response handshake
- m_rsp_addr_i  in  32; m_rsp_line_i  in  LINE_W
- err_o  out  1  sticky: response address mismatched the issued address

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: at most one of i_req_ready_o/d_req_ready_o high, combinationally, for the winner. Both are low when there are no requests.
- Arbitration: data wins over instruction, except when starve_cnt == STARVE_LIMIT; then instruction wins.
- starve_cnt increments on a data grant with i_req_valid_i high. It clears on an instruction grant. It saturates at STARVE_LIMIT.
- Grant handshake (valid & ready) latches addr, we, wdata and the owner, then moves to ISSUE. Instruction requests latch we = 0.
- ISSUE: m_req_valid_o = 1 with the latched fields, held stable until m_req_ready_i. Then move to WAIT.
- WAIT: m_rsp_ready_o = 1. On m_rsp_valid_i, capture the line and addr into the response buffer.
  - If m_rsp_addr_i differs from the latched addr, set err_o. The response is still delivered.
  - Writes also receive a memory response; its line is delivered but is don't-care.
- DELIVER: assert the owner's x_rsp_valid_o with the buffered addr/line, held until x_rsp_ready_i. Then return to IDLE.
- Flush: i_flush_i while the owner is instruction, in ISSUE, WAIT or DELIVER, sets a drop flag.
  - The memory transaction still completes (ISSUE and WAIT proceed normally).
  - DELIVER is skipped: i_rsp_valid_o is never raised, and the FSM returns to IDLE from WAIT.
  - If i_flush_i is high in the same cycle as the WAIT response capture, the response is dropped.
  - Flush has no effect on data transactions or in IDLE. The drop flag clears on return to IDLE.
- Single outstanding transaction; no request is accepted outside IDLE.

## Timing
- Reset values: FSM = IDLE, all valid/ready outputs 0, addr/line/wdata outputs 0, err_o 0, starve_cnt 0, drop flag 0.
- Grant accepted at cycle T → m_req_valid_o high at T+1.
- Memory response captured at cycle R → x_rsp_valid_o high at R+1.
- Owner ready at cycle D → IDLE at D+1, where a new grant may occur. Minimum 4 cycles between back-to-back grants with zero-wait memory.
- All outputs are registered or decoded from state only, except the IDLE req_ready_o lines (combinational from the valid inputs and starve_cnt).
- Asynchronous reset mid-transaction abandons it: no response is delivered, and memory-side state is the memory's concern.

## Test plan
- Single icache request at addr 0x40; memory returns line 0xAB.. after 3 cycles → i_rsp_valid_o carries addr 0x40 and the line at R+1; d_rsp_valid_o stays 0.
- Simultaneous i and d requests, STARVE_LIMIT=4 → d granted first. Hold both valid for 5 grants → sequence d,d,d,d,i. starve_cnt returns to 0.
- Dcache writeback at 0x80 with wdata pattern → m_req_we_o=1 and m_req_wdata_o matches for the whole ISSUE period while m_req_ready_i is held low 4 cycles.
- i_flush_i pulsed during WAIT on icache transaction → no i_rsp_valid_o. Next i request at 0x100 is granted and returns normally.
- m_rsp_addr_i = 0x44 for an issued 0x40 → err_o rises the cycle after capture and stays 1 until reset. Line still delivered.
- Reset asserted during DELIVER with i_rsp_ready_i low → all valids 0 immediately, FSM IDLE after reset release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory line port between the icache refill path and the dcache refill/writeback path.
// One transaction at a time; the response is buffered and returned to whichever side owns it.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LINE_W       = 512
) (
    input  logic              clk_i,
    input  logic              rstn_i,

    input  logic              i_req_valid_i,
    output logic              i_req_ready_o,
    input  logic [31:0]       i_req_addr_i,
    input  logic              i_flush_i,
    output logic              i_rsp_valid_o,
    input  logic              i_rsp_ready_i,
    output logic [31:0]       i_rsp_addr_o,
    output logic [LINE_W-1:0] i_rsp_line_o,

    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic [31:0]       d_req_addr_i,
    input  logic              d_req_we_i,
    input  logic [LINE_W-1:0] d_req_wdata_i,
    output logic              d_rsp_valid_o,
    input  logic              d_rsp_ready_i,
    output logic [31:0]       d_rsp_addr_o,
    output logic [LINE_W-1:0] d_rsp_line_o,

    output logic              m_req_valid_o,
    input  logic              m_req_ready_i,
    output logic [31:0]       m_req_addr_o,
    output logic              m_req_we_o,
    output logic [LINE_W-1:0] m_req_wdata_o,
    input  logic              m_rsp_valid_i,
    output logic              m_rsp_ready_o,
    input  logic [31:0]       m_rsp_addr_i,
    input  logic [LINE_W-1:0] m_rsp_line_i,

    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    state_t            state;
    logic [CW-1:0]     starve_cnt;
    logic              own_i;
    logic              drop;
    logic [31:0]       rsp_addr;
    logic [LINE_W-1:0] rsp_line;

    logic starved, i_win, d_win, idle, flush_hit;

    // Data normally wins; a waiting fetch gets through once data has had STARVE_LIMIT turns.
    assign starved   = (starve_cnt == STARVE_MAX);
    assign i_win     = i_req_valid_i && (!d_req_valid_i || starved);
    assign d_win     = d_req_valid_i && !i_win;
    assign idle      = (state == IDLE);
    assign flush_hit = i_flush_i && own_i;

    assign i_req_ready_o = idle && i_win;
    assign d_req_ready_o = idle && d_win;

    assign i_rsp_addr_o = rsp_addr;
    assign i_rsp_line_o = rsp_line;
    assign d_rsp_addr_o = rsp_addr;
    assign d_rsp_line_o = rsp_line;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            own_i         <= 1'b0;
            drop          <= 1'b0;
            rsp_addr      <= '0;
            rsp_line      <= '0;
            m_req_valid_o <= 1'b0;
            m_req_addr_o  <= '0;
            m_req_we_o    <= 1'b0;
            m_req_wdata_o <= '0;
            m_rsp_ready_o <= 1'b0;
            i_rsp_valid_o <= 1'b0;
            d_rsp_valid_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (i_req_ready_o || d_req_ready_o) begin
                        own_i         <= i_req_ready_o;
                        m_req_addr_o  <= i_req_ready_o ? i_req_addr_i : d_req_addr_i;
                        m_req_we_o    <= d_req_ready_o && d_req_we_i;
                        m_req_wdata_o <= d_req_ready_o ? d_req_wdata_i : '0;
                        m_req_valid_o <= 1'b1;
                        state         <= ISSUE;
                        if (i_req_ready_o)
                            starve_cnt <= '0;
                        else if (i_req_valid_i && !starved)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (flush_hit) drop <= 1'b1;
                    if (m_req_ready_i) begin
                        m_req_valid_o <= 1'b0;
                        m_rsp_ready_o <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush_hit) drop <= 1'b1;
                    if (m_rsp_valid_i) begin
                        m_rsp_ready_o <= 1'b0;
                        rsp_addr      <= m_rsp_addr_i;
                        rsp_line      <= m_rsp_line_i;
                        if (m_rsp_addr_i != m_req_addr_o) err_o <= 1'b1;
                        // A flushed fetch finishes its memory transaction but is never returned.
                        if (own_i && (drop || i_flush_i)) begin
                            drop  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            i_rsp_valid_o <= own_i;
                            d_rsp_valid_o <= !own_i;
                            state         <= DELIVER;
                        end
                    end
                end
                DELIVER: begin
                    if (flush_hit) begin
                        i_rsp_valid_o <= 1'b0;
                        state         <= IDLE;
                    end else if (own_i ? i_rsp_ready_i : d_rsp_ready_i) begin
                        i_rsp_valid_o <= 1'b0;
                        d_rsp_valid_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model is checked against the DUT every cycle,
// and a few literal expectations pin the model.
module tb_mem_arbiter;
    localparam int LW = 512;
    localparam int SL = 4;

    logic          clk_i = 1'b0, rstn_i;
    logic          i_req_valid_i, i_req_ready_o, i_flush_i, i_rsp_valid_o, i_rsp_ready_i;
    logic [31:0]   i_req_addr_i, i_rsp_addr_o;
    logic [LW-1:0] i_rsp_line_o;
    logic          d_req_valid_i, d_req_ready_o, d_req_we_i, d_rsp_valid_o, d_rsp_ready_i;
    logic [31:0]   d_req_addr_i, d_rsp_addr_o;
    logic [LW-1:0] d_req_wdata_i, d_rsp_line_o;
    logic          m_req_valid_o, m_req_ready_i, m_req_we_o, m_rsp_valid_i, m_rsp_ready_o;
    logic [31:0]   m_req_addr_o, m_rsp_addr_i;
    logic [LW-1:0] m_req_wdata_o, m_rsp_line_i;
    logic          err_o;

    mem_arbiter #(.STARVE_LIMIT(SL), .LINE_W(LW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .i_req_valid_i(i_req_valid_i), .i_req_ready_o(i_req_ready_o), .i_req_addr_i(i_req_addr_i),
        .i_flush_i(i_flush_i), .i_rsp_valid_o(i_rsp_valid_o), .i_rsp_ready_i(i_rsp_ready_i),
        .i_rsp_addr_o(i_rsp_addr_o), .i_rsp_line_o(i_rsp_line_o),
        .d_req_valid_i(d_req_valid_i), .d_req_ready_o(d_req_ready_o), .d_req_addr_i(d_req_addr_i),
        .d_req_we_i(d_req_we_i), .d_req_wdata_i(d_req_wdata_i), .d_rsp_valid_o(d_rsp_valid_o),
        .d_rsp_ready_i(d_rsp_ready_i), .d_rsp_addr_o(d_rsp_addr_o), .d_rsp_line_o(d_rsp_line_o),
        .m_req_valid_o(m_req_valid_o), .m_req_ready_i(m_req_ready_i), .m_req_addr_o(m_req_addr_o),
        .m_req_we_o(m_req_we_o), .m_req_wdata_o(m_req_wdata_o), .m_rsp_valid_i(m_rsp_valid_i),
        .m_rsp_ready_o(m_rsp_ready_o), .m_rsp_addr_i(m_rsp_addr_i), .m_rsp_line_i(m_rsp_line_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_fail = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin n_fail++; $display("FAIL %s: got %0b expected %0b", nm, act, exp); end
    endtask
    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, act, exp); end
    endtask
    task automatic chkl(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, act, exp); end
    endtask

    function automatic logic [LW-1:0] line_of(input logic [31:0] a);
        return {16{a ^ 32'hABAB_ABAB}};
    endfunction

    localparam logic [LW-1:0] WPAT = {16{32'hDEAD_BEEF}} ^ {{(LW-64){1'b0}}, 64'h0123_4567_89AB_CDEF};

    // ---------------- memory responder ----------------
    int          req_wait = 0, rsp_wait = 0;
    logic [31:0] addr_xor = '0;
    logic [31:0] ma;
    initial begin
        m_req_ready_i = 0; m_rsp_valid_i = 0; m_rsp_addr_i = '0; m_rsp_line_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (rstn_i && m_req_valid_o) begin
                ma = m_req_addr_o;
                repeat (req_wait) begin @(posedge clk_i); #1; end
                m_req_ready_i = 1;
                @(posedge clk_i); #1;
                m_req_ready_i = 0;
                repeat (rsp_wait) begin @(posedge clk_i); #1; end
                m_rsp_valid_i = 1; m_rsp_addr_i = ma ^ addr_xor; m_rsp_line_i = line_of(ma);
                @(posedge clk_i); #1;
                m_rsp_valid_i = 0;
            end
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    // ph: 0 nothing outstanding, 1 request offered to memory, 2 awaiting memory, 3 offering response
    int            ph, m_starve;
    logic          m_own_i, m_we, m_drop, m_err, ei, ed;
    logic [31:0]   m_addr, m_raddr;
    logic [LW-1:0] m_wdata, m_rline;
    logic          grant_log[$];
    int            n_i_del = 0, n_d_del = 0, i_valid_cycles = 0, we_cycles = 0;
    logic [31:0]   last_i_addr, last_d_addr;
    logic [LW-1:0] last_i_line;

    always @(negedge clk_i) begin
        if (!rstn_i) begin
            ph = 0; m_starve = 0; m_err = 0; m_drop = 0; m_own_i = 0;
        end else begin
            ei = (ph == 0) && i_req_valid_i && (!d_req_valid_i || m_starve == SL);
            ed = (ph == 0) && d_req_valid_i && !ei;
            chk1("i_req_ready", i_req_ready_o, ei);
            chk1("d_req_ready", d_req_ready_o, ed);
            chk1("m_req_valid", m_req_valid_o, ph == 1);
            if (ph == 1) begin
                chk32("m_req_addr", m_req_addr_o, m_addr);
                chk1("m_req_we", m_req_we_o, m_we);
                if (m_we) chkl("m_req_wdata", m_req_wdata_o, m_wdata);
            end
            chk1("m_rsp_ready", m_rsp_ready_o, ph == 2);
            chk1("i_rsp_valid", i_rsp_valid_o, ph == 3 && m_own_i);
            chk1("d_rsp_valid", d_rsp_valid_o, ph == 3 && !m_own_i);
            if (ph == 3 && m_own_i) begin
                chk32("i_rsp_addr", i_rsp_addr_o, m_raddr);
                chkl("i_rsp_line", i_rsp_line_o, m_rline);
            end
            if (ph == 3 && !m_own_i) begin
                chk32("d_rsp_addr", d_rsp_addr_o, m_raddr);
                chkl("d_rsp_line", d_rsp_line_o, m_rline);
            end
            chk1("err", err_o, m_err);

            if (i_rsp_valid_o) i_valid_cycles++;
            if (m_req_valid_o && m_req_we_o && m_req_wdata_o == WPAT) we_cycles++;
            if (i_rsp_valid_o && i_rsp_ready_i) begin n_i_del++; last_i_addr = i_rsp_addr_o; last_i_line = i_rsp_line_o; end
            if (d_rsp_valid_o && d_rsp_ready_i) begin n_d_del++; last_d_addr = d_rsp_addr_o; end

            case (ph)
                0: if (ei || ed) begin
                    grant_log.push_back(ei);
                    m_own_i = ei;
                    m_addr  = ei ? i_req_addr_i : d_req_addr_i;
                    m_we    = ed && d_req_we_i;
                    m_wdata = d_req_wdata_i;
                    m_drop  = 0;
                    if (ei) m_starve = 0;
                    else if (i_req_valid_i && m_starve < SL) m_starve++;
                    ph = 1;
                end
                1: begin
                    if (m_own_i && i_flush_i) m_drop = 1;
                    if (m_req_ready_i) ph = 2;
                end
                2: begin
                    if (m_own_i && i_flush_i) m_drop = 1;
                    if (m_rsp_valid_i) begin
                        m_raddr = m_rsp_addr_i; m_rline = m_rsp_line_i;
                        if (m_rsp_addr_i != m_addr) m_err = 1;
                        ph = m_drop ? 0 : 3;
                    end
                end
                default: begin
                    if (m_own_i && i_flush_i) ph = 0;
                    else if (m_own_i ? i_rsp_ready_i : d_rsp_ready_i) ph = 0;
                end
            endcase
        end
    end

    // ---------------- requester tasks ----------------
    task automatic req(input bit is_i, input logic [31:0] a, input logic we, input logic [LW-1:0] wd);
        int t;
        if (is_i) begin i_req_valid_i = 1; i_req_addr_i = a; end
        else begin d_req_valid_i = 1; d_req_addr_i = a; d_req_we_i = we; d_req_wdata_i = wd; end
        t = 0;
        @(negedge clk_i);
        while (!(is_i ? i_req_ready_o : d_req_ready_o) && t < 50) begin @(negedge clk_i); t++; end
        if (t >= 50) chk1("grant_timeout", 1'b1, 1'b0);
        @(posedge clk_i); #1;
        if (is_i) i_req_valid_i = 0; else d_req_valid_i = 0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin @(posedge clk_i); #2; t++; end while (ph != 0 && t < 100);
        if (t >= 100) chk1("idle_timeout", 1'b1, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t, n0, v0;
        rstn_i = 0; i_req_valid_i = 0; i_req_addr_i = '0; i_flush_i = 0; i_rsp_ready_i = 1;
        d_req_valid_i = 0; d_req_addr_i = '0; d_req_we_i = 0; d_req_wdata_i = '0; d_rsp_ready_i = 1;
        #13;
        chk1("rst_m_req_valid", m_req_valid_o, 1'b0);
        chk1("rst_m_rsp_ready", m_rsp_ready_o, 1'b0);
        chk1("rst_i_rsp_valid", i_rsp_valid_o, 1'b0);
        chk1("rst_d_rsp_valid", d_rsp_valid_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk32("rst_m_req_addr", m_req_addr_o, 32'h0);
        chkl("rst_i_rsp_line", i_rsp_line_o, '0);
        @(posedge clk_i); #1; rstn_i = 1;
        @(posedge clk_i); #1;

        // single fetch, memory answers 3 cycles late
        rsp_wait = 3;
        req(1, 32'h40, 0, '0);
        wait_idle();
        chk32("t1_n_i_del", n_i_del, 1);
        chk32("t1_n_d_del", n_d_del, 0);
        chk32("t1_addr", last_i_addr, 32'h40);
        chkl("t1_line", last_i_line, {16{32'hABAB_ABEB}});
        rsp_wait = 0;

        // both requesters held: d,d,d,d,i
        grant_log.delete();
        i_req_valid_i = 1; i_req_addr_i = 32'h200;
        d_req_valid_i = 1; d_req_addr_i = 32'h300; d_req_we_i = 0;
        t = 0;
        do begin @(negedge clk_i); #1; t++; end while (grant_log.size() < 5 && t < 200);
        if (t >= 200) chk1("t2_timeout", 1'b1, 1'b0);
        @(posedge clk_i); #1;
        i_req_valid_i = 0; d_req_valid_i = 0;
        wait_idle();
        for (int k = 0; k < 5; k++)
            chk1($sformatf("t2_grant%0d", k), (k < grant_log.size()) ? grant_log[k] : 1'bx, k == 4);
        chk32("t2_starve", m_starve, 0);

        // writeback with memory stalling the request 4 cycles
        req_wait = 4; we_cycles = 0; n0 = n_d_del;
        req(0, 32'h80, 1, WPAT);
        wait_idle();
        chk32("t3_we_cycles", we_cycles, 5);
        chk32("t3_n_d_del", n_d_del, n0 + 1);
        req_wait = 0;

        // flush during WAIT drops the fetch; next fetch is normal
        rsp_wait = 3; n0 = n_i_del; v0 = i_valid_cycles;
        req(1, 32'h200, 0, '0);
        t = 0;
        while (!m_rsp_ready_o && t < 50) begin @(negedge clk_i); t++; end
        if (t >= 50) chk1("t4_wait_timeout", 1'b1, 1'b0);
        @(posedge clk_i); #1; i_flush_i = 1;
        @(posedge clk_i); #1; i_flush_i = 0;
        wait_idle();
        chk32("t4_no_delivery", n_i_del, n0);
        chk32("t4_no_valid", i_valid_cycles, v0);
        rsp_wait = 0;
        req(1, 32'h100, 0, '0);
        wait_idle();
        chk32("t4_next_n", n_i_del, n0 + 1);
        chk32("t4_next_addr", last_i_addr, 32'h100);

        // response address mismatch: sticky err, line still delivered
        addr_xor = 32'h4;
        req(1, 32'h40, 0, '0);
        wait_idle();
        addr_xor = '0;
        chk1("t5_err", err_o, 1'b1);
        chk32("t5_addr", last_i_addr, 32'h44);
        chkl("t5_line", last_i_line, {16{32'hABAB_ABEB}});
        req(0, 32'h500, 0, '0);
        wait_idle();
        chk1("t5_err_sticky", err_o, 1'b1);

        // reset while a fetch response is being offered
        i_rsp_ready_i = 0;
        req(1, 32'h600, 0, '0);
        t = 0;
        while (!i_rsp_valid_o && t < 50) begin @(negedge clk_i); t++; end
        if (t >= 50) chk1("t6_valid_timeout", 1'b1, 1'b0);
        @(posedge clk_i); #1;
        rstn_i = 0; #1;
        chk1("t6_i_rsp_valid", i_rsp_valid_o, 1'b0);
        chk1("t6_d_rsp_valid", d_rsp_valid_o, 1'b0);
        chk1("t6_m_req_valid", m_req_valid_o, 1'b0);
        chk1("t6_err", err_o, 1'b0);
        i_rsp_ready_i = 1;
        @(posedge clk_i); #1; rstn_i = 1;
        n0 = n_d_del;
        req(0, 32'h700, 0, '0);
        wait_idle();
        chk32("t6_after_n", n_d_del, n0 + 1);
        chk32("t6_after_addr", last_d_addr, 32'h700);

        repeat (3) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end
endmodule
